// File: rtl/div_seq_pkg.sv
// div_seq_pkg: shared widths, FSM state codes and sign helper for the sequential divider.
package div_seq_pkg;
    localparam int DATA_W = 32;
    localparam int CNT_W = 6;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W);

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_t;

    // Two's-complement negate when neg is set; 0x80000000 maps to itself.
    function automatic logic [DATA_W-1:0] mag(input logic neg, input logic [DATA_W-1:0] v);
        return neg ? ~v + 1'b1 : v;
    endfunction
endpackage

// File: rtl/div_seq_if.sv
// div_seq_if: request/result bundle between the EX stage and the divider.
interface div_seq_if;
    import div_seq_pkg::*;
    logic signed_div;
    logic [DATA_W-1:0] opdata1;
    logic [DATA_W-1:0] opdata2;
    logic start;
    logic annul;
    logic [2*DATA_W-1:0] result;
    logic ready;

    modport master (output signed_div, opdata1, opdata2, start, annul, input result, ready);
    modport slave (input signed_div, opdata1, opdata2, start, annul, output result, ready);
endinterface

// File: rtl/div_seq.sv
// div_seq: multi-cycle radix-2 restoring divider for DIV/DIVU, result {remainder, quotient}.
module div_seq
    import div_seq_pkg::*;
(
    input logic clk,
    input logic rst,
    div_seq_if.slave bus
);
    div_state_t state, next;
    logic [CNT_W-1:0] cnt;
    logic [2*DATA_W:0] dividend;
    logic [DATA_W-1:0] divisor;
    logic neg1, neg2, accept, op1_neg, op2_neg;
    logic [DATA_W:0] diff;

    assign accept = bus.start && !bus.annul;
    assign op1_neg = bus.signed_div && bus.opdata1[DATA_W-1];
    assign op2_neg = bus.signed_div && bus.opdata2[DATA_W-1];
    // Trial subtraction of the shifted partial remainder; bit DATA_W is the borrow.
    assign diff = {1'b0, dividend[2*DATA_W-1:DATA_W]} - {1'b0, divisor};

    always_comb begin
        next = state;
        case (state)
            DIV_FREE:   next = accept ? (bus.opdata2 == '0 ? DIV_BYZERO : DIV_ON) : DIV_FREE;
            DIV_BYZERO: next = bus.annul ? DIV_FREE : DIV_END;
            DIV_ON:     next = bus.annul ? DIV_FREE : (cnt == LAST_CNT ? DIV_END : DIV_ON);
            DIV_END:    next = (bus.annul || !bus.start) ? DIV_FREE : DIV_END;
            default:    next = DIV_FREE;
        endcase
    end

    always_ff @(posedge clk)
        state <= rst ? DIV_FREE : next;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            dividend <= '0;
            divisor <= '0;
            neg1 <= 1'b0;
            neg2 <= 1'b0;
            bus.result <= '0;
            bus.ready <= 1'b0;
        end else if (next == DIV_FREE) begin
            cnt <= '0;
            bus.result <= '0;
            bus.ready <= 1'b0;
        end else if (state == DIV_FREE) begin
            neg1 <= op1_neg;
            neg2 <= op2_neg;
            divisor <= mag(op2_neg, bus.opdata2);
            dividend <= {{DATA_W{1'b0}}, mag(op1_neg, bus.opdata1), 1'b0};
            cnt <= '0;
        end else if (state == DIV_BYZERO) begin
            bus.result <= '0;
            bus.ready <= 1'b1;
        end else if (state == DIV_ON && cnt != LAST_CNT) begin
            dividend <= diff[DATA_W] ? {dividend[2*DATA_W-1:0], 1'b0}
                                     : {diff[DATA_W-1:0], dividend[DATA_W-1:0], 1'b1};
            cnt <= cnt + 1'b1;
        end else if (state == DIV_ON) begin
            bus.result <= {mag(neg1, dividend[2*DATA_W:DATA_W+1]), mag(neg1 != neg2, dividend[DATA_W-1:0])};
            bus.ready <= 1'b1;
        end
    end
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: randomized and directed checks of div_seq against an arithmetic reference model.
module tb_div_seq;
    import div_seq_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int failures = 0;

    div_seq_if bus();
    div_seq dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic sg, input logic [31:0] a, input logic [31:0] b);
        longint q, r, sa, sb;
        if (b == 32'd0) return 64'd0;
        sa = sg ? longint'($signed(a)) : longint'({32'd0, a});
        sb = sg ? longint'($signed(b)) : longint'({32'd0, b});
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one request, scrambles operands after the accept edge, waits for ready.
    task automatic run_op(input logic sg, input logic [31:0] a, input logic [31:0] b,
                          output logic [63:0] res, output int lat);
        bus.signed_div = sg;
        bus.opdata1 = a;
        bus.opdata2 = b;
        bus.start = 1'b1;
        lat = 0;
        do begin
            tick();
            lat++;
            bus.opdata1 = $urandom;
            bus.opdata2 = $urandom;
            bus.signed_div = 1'($urandom_range(1));
        end while (!bus.ready && lat < 60);
        res = bus.result;
    endtask

    task automatic release_op();
        bus.start = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.annul = 1'b0;
        bus.signed_div = 1'b0;
        bus.opdata1 = '0;
        bus.opdata2 = '0;
        repeat (3) tick();
        rst = 1'b0;
        checks++;
        if (bus.ready !== 1'b0 || bus.result !== 64'd0 || dut.state !== DIV_FREE) begin
            failures++;
            $display("FAIL reset ready=%b result=%h state=%0d", bus.ready, bus.result, dut.state);
        end
    endtask

    task automatic test_divu_basic();
        logic [63:0] res;
        int lat;
        run_op(1'b0, 32'd100, 32'd7, res, lat);
        checks++;
        if (lat !== 34 || res !== 64'h00000002_0000000E) begin
            failures++;
            $display("FAIL divu_100_7 lat=%0d res=%h exp lat=34 res=%h", lat, res, 64'h00000002_0000000E);
        end
        repeat (2) tick();
        checks++;
        if (bus.ready !== 1'b1 || bus.result !== 64'h00000002_0000000E) begin
            failures++;
            $display("FAIL end_hold ready=%b result=%h", bus.ready, bus.result);
        end
        release_op();
        checks++;
        if (bus.ready !== 1'b0 || bus.result !== 64'd0 || dut.state !== DIV_FREE) begin
            failures++;
            $display("FAIL end_release ready=%b result=%h state=%0d", bus.ready, bus.result, dut.state);
        end
    endtask

    task automatic test_div_signed();
        logic [63:0] res;
        int lat;
        run_op(1'b1, 32'hFFFFFFF9, 32'd2, res, lat);
        checks++;
        if (res !== 64'hFFFFFFFF_FFFFFFFD || lat !== 34) begin
            failures++;
            $display("FAIL div_m7_2 res=%h lat=%0d exp %h", res, lat, 64'hFFFFFFFF_FFFFFFFD);
        end
        release_op();
        run_op(1'b1, 32'd7, 32'hFFFFFFFE, res, lat);
        checks++;
        if (res !== 64'h00000001_FFFFFFFD || lat !== 34) begin
            failures++;
            $display("FAIL div_7_m2 res=%h lat=%0d exp %h", res, lat, 64'h00000001_FFFFFFFD);
        end
        release_op();
    endtask

    task automatic test_div_zero();
        logic [63:0] res;
        int lat;
        for (int s = 0; s < 2; s++) begin
            bus.signed_div = 1'(s);
            bus.opdata1 = 32'h1234_5678;
            bus.opdata2 = 32'd0;
            bus.start = 1'b1;
            tick();
            checks++;
            if (dut.state !== DIV_BYZERO || bus.ready !== 1'b0) begin
                failures++;
                $display("FAIL byzero_e0 signed=%0d state=%0d ready=%b exp state=%0d", s, dut.state, bus.ready, DIV_BYZERO);
            end
            tick();
            res = bus.result;
            checks++;
            if (bus.ready !== 1'b1 || res !== 64'd0 || dut.state !== DIV_END) begin
                failures++;
                $display("FAIL byzero_e1 signed=%0d ready=%b res=%h state=%0d", s, bus.ready, res, dut.state);
            end
            release_op();
        end
        run_op(1'b1, 32'h8000_0000, 32'd0, res, lat);
        checks++;
        if (lat !== 2 || res !== 64'd0) begin
            failures++;
            $display("FAIL byzero_lat lat=%0d res=%h exp lat=2 res=0", lat, res);
        end
        release_op();
    endtask

    task automatic test_boundary();
        logic sg [3] = '{1'b0, 1'b1, 1'b0};
        logic [31:0] a [3] = '{32'hFFFFFFFF, 32'h80000000, 32'd5};
        logic [31:0] b [3] = '{32'd1, 32'hFFFFFFFF, 32'd9};
        logic [63:0] exp [3] = '{64'h00000000_FFFFFFFF, 64'h00000000_80000000, 64'h00000005_00000000};
        logic [63:0] res;
        int lat;
        for (int i = 0; i < 3; i++) begin
            run_op(sg[i], a[i], b[i], res, lat);
            checks++;
            if (res !== exp[i] || lat !== 34) begin
                failures++;
                $display("FAIL boundary_%0d res=%h lat=%0d exp %h", i, res, lat, exp[i]);
            end
            release_op();
        end
    endtask

    task automatic test_annul();
        logic [63:0] res;
        int lat;
        bus.start = 1'b1;
        bus.annul = 1'b1;
        bus.opdata1 = 32'd50;
        bus.opdata2 = 32'd5;
        tick();
        checks++;
        if (dut.state !== DIV_FREE || bus.ready !== 1'b0) begin
            failures++;
            $display("FAIL annul_free state=%0d ready=%b", dut.state, bus.ready);
        end
        bus.annul = 1'b0;
        bus.signed_div = 1'b0;
        bus.opdata1 = 32'd100;
        bus.opdata2 = 32'd7;
        tick();
        repeat (9) tick();
        bus.annul = 1'b1;
        tick();
        bus.annul = 1'b0;
        bus.start = 1'b0;
        checks++;
        if (dut.state !== DIV_FREE || bus.ready !== 1'b0 || bus.result !== 64'd0) begin
            failures++;
            $display("FAIL annul_on state=%0d ready=%b result=%h", dut.state, bus.ready, bus.result);
        end
        repeat (3) tick();
        checks++;
        if (bus.ready !== 1'b0) begin
            failures++;
            $display("FAIL annul_quiet ready=%b exp 0", bus.ready);
        end
        run_op(1'b0, 32'd12, 32'd4, res, lat);
        checks++;
        if (res !== 64'h00000000_00000003 || lat !== 34) begin
            failures++;
            $display("FAIL annul_restart res=%h lat=%0d", res, lat);
        end
        bus.annul = 1'b1;
        tick();
        bus.annul = 1'b0;
        checks++;
        if (dut.state !== DIV_FREE || bus.ready !== 1'b0 || bus.result !== 64'd0) begin
            failures++;
            $display("FAIL annul_end state=%0d ready=%b result=%h", dut.state, bus.ready, bus.result);
        end
        release_op();
    endtask

    task automatic test_reset_mid();
        logic [63:0] res;
        int lat;
        bus.signed_div = 1'b1;
        bus.opdata1 = 32'hFFFF0000;
        bus.opdata2 = 32'd3;
        bus.start = 1'b1;
        tick();
        repeat (19) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.start = 1'b0;
        checks++;
        if (dut.state !== DIV_FREE || bus.ready !== 1'b0 || bus.result !== 64'd0 || dut.cnt !== '0) begin
            failures++;
            $display("FAIL reset_mid state=%0d ready=%b result=%h cnt=%0d", dut.state, bus.ready, bus.result, dut.cnt);
        end
        run_op(1'b0, 32'd9, 32'd3, res, lat);
        checks++;
        if (res !== 64'h00000000_00000003 || lat !== 34) begin
            failures++;
            $display("FAIL reset_restart res=%h lat=%0d", res, lat);
        end
        release_op();
    endtask

    task automatic test_random();
        logic [63:0] res, exp;
        logic [31:0] a, b;
        logic sg;
        int lat;
        for (int i = 0; i < 40; i++) begin
            sg = 1'($urandom_range(1));
            a = $urandom;
            case (i % 4)
                0: b = $urandom;
                1: b = 32'($urandom_range(1, 255));
                2: b = (i % 8 == 2) ? 32'd0 : 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            exp = model(sg, a, b);
            run_op(sg, a, b, res, lat);
            checks++;
            if (res !== exp || lat !== (b == 32'd0 ? 2 : 34)) begin
                failures++;
                $display("FAIL random_%0d sg=%b a=%h b=%h res=%h lat=%0d exp %h", i, sg, a, b, res, lat, exp);
            end
            release_op();
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] res;
        int lat;
        run_op(1'b1, 32'h8000_0000, 32'd7, res, lat);
        checks++;
        if (res !== model(1'b1, 32'h8000_0000, 32'd7)) begin
            failures++;
            $display("FAIL b2b_first res=%h exp %h", res, model(1'b1, 32'h8000_0000, 32'd7));
        end
        release_op();
        run_op(1'b0, 32'h8000_0000, 32'd7, res, lat);
        checks++;
        if (res !== 64'h00000002_12492492 || lat !== 34) begin
            failures++;
            $display("FAIL b2b_second res=%h lat=%0d exp %h", res, lat, 64'h00000002_12492492);
        end
        release_op();
    endtask

    initial begin
        test_reset();
        test_divu_basic();
        test_div_signed();
        test_div_zero();
        test_boundary();
        test_annul();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Multi-cycle 32-bit divider that executes DIV/DIVU for the EX stage.
- EX raises start with the operands and holds the pipeline stalled until ready returns.
- Result is {remainder, quotient}; EX writes it to HI/LO.
- Runs a radix-2 restoring algorithm, one quotient bit per cycle, sequenced by a 4-state FSM.

Parameters:
- DATA_W, 32, operand width; result is 2*DATA_W.
- CNT_W, 6, iteration counter width; must hold DATA_W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- signed_div  in  1  1 = DIV (two's complement), 0 = DIVU.
- opdata1  in  32  dividend (rs).
- opdata2  in  32  divisor (rt).
- start  in  1  request; EX holds it high until it sees ready.
- annul  in  1  cancel; flush from the pipeline controller.
- result  out  64  {remainder[63:32], quotient[31:0]}; registered.
- ready  out  1  result valid; registered.

Behaviour:
- Reset: on a rising edge with rst=1, state=FREE, cnt=0, result=0, ready=0, internal regs=0. This overrides any operation in progress.
- States: FREE, BYZERO, ON, END. Encodings are 2-bit constants.
- FREE:
  - start=1, annul=0, opdata2==0 -> BYZERO.
  - start=1, annul=0, divisor nonzero -> ON, cnt=0.
  - Operands are captured on this edge. When signed_div=1, each negative operand is replaced by its magnitude. The original sign bits are latched.
  - Dividend register (65 bits) loads {32'b0, |dividend|, 1'b0}.
  - Otherwise the FSM stays in FREE with ready=0 and result=0.
- ON, one iteration per edge while cnt<32:
  - diff = dividend_reg[63:32] - {1'b0, divisor}, computed 33 bits wide.
  - If diff is negative, dividend_reg shifts left 1 with 0 in.
  - Otherwise dividend_reg = {diff[31:0], dividend_reg[31:0], 1'b1}.
  - cnt increments.
- ON, edge at cnt==32:
  - quotient = dividend_reg[31:0]; remainder = dividend_reg[64:33].
  - If signed_div=1 and the sign bits differ, negate quotient.
  - If signed_div=1 and the dividend was negative, negate remainder.
  - Load result, set ready=1, go to END.
- Latency, accept edge = E0:
  - Iterations on E1..E32; ready=1 visible after E33.
  - Divide-by-zero: BYZERO on E0; on E1 enter END with result=0, ready=1.
- END:
  - ready and result hold while start=1.
  - When start=0, the next edge goes to FREE with ready=0 and result=0.
- annul:
  - annul=1 in ON, BYZERO or END -> FREE on the next edge, with ready=0, result=0, cnt=0.
  - annul together with start in FREE -> no accept.
- Operand changes after E0 are ignored. start seen outside FREE has no effect.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0. This is the natural two's-complement wrap; no exception is raised.
- Magnitude of 0x80000000 is 0x80000000, treated as unsigned 2^31.

Decomposition:
- defines.v (shared include):
  - DivFree/DivByZero/DivOn/DivEnd state codes.
  - DivResultReady/DivResultNotReady, DivStart/DivStop.
  - DoubleRegBus (63:0).
- EX stage (not this block):
  - Adds EXE_DIV_OP/EXE_DIVU_OP aluop codes.
  - Drives start.
  - Raises stallreq while start=1 and ready=0.
- No sub-module. The 33-bit trial subtractor is inline.

Test Plan:
1. DIVU 100/7: opdata1=0x64, opdata2=7, start held. ready rises after E33 with result=64'h00000002_0000000E. Then start=0 -> FREE, ready=0 and result=0 next cycle.
2. DIV -7/2: opdata1=0xFFFFFFF9, opdata2=2, signed_div=1. Result 64'hFFFFFFFF_FFFFFFFD (rem -1, quot -3). Also check DIV 7/-2 -> 64'h00000001_FFFFFFFD.
3. Divide-by-zero: opdata2=0, start=1. ready=1 after E1 with result=0. Check no ON state is entered, in both signed and unsigned mode.
4. Boundary values:
   - DIVU 0xFFFFFFFF/1 -> 64'h00000000_FFFFFFFF.
   - DIV 0x80000000/0xFFFFFFFF -> 64'h00000000_80000000.
   - DIVU 5/9 -> 64'h00000005_00000000.
5. Annul mid-operation: assert annul for one cycle at E10. Next state is FREE and ready stays 0. A fresh start 12/4 then yields 64'h00000000_00000003 after 34 edges.
6. Reset mid-operation: rst=1 for one edge at E20. All outputs become 0 and the state is FREE. After release, a new 9/3 completes with 64'h00000000_00000003.
